// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice: FSM state encoding,
// the hardwired-zero register index and the NOP instruction word.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun,
        StStallLu,
        StMemWait,
        StDrain,
        StHalted
    } state_e;

    localparam int unsigned REG_ZERO = 0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a load in EX.
// Register zero is hardwired, so it never creates a hazard.
module hazard_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_load_i,
    input  logic              ex_wr_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    output logic              lu_o
);

    logic rs_hit, rt_hit;

    assign rs_hit = id_use_rs_i && (id_rs_i == ex_dest_i);
    assign rt_hit = id_use_rt_i && (id_rt_i == ex_dest_i);
    assign lu_o   = id_valid_i && ex_valid_i && ex_load_i && ex_wr_i &&
                    (ex_dest_i != REG_AW'(REG_ZERO)) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencer for the IF-ID-EX-WB pipeline, including halt drain.
// Optional saturating performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef PIPE_CTRL_PERF_EN
    , parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_wr_en_i,
    input  logic [REG_AW-1:0] id_dest_i,
    input  logic              id_is_load_i,
    input  logic              id_is_halt_i,
    input  logic              ex_br_taken_i,
    input  logic              dmem_busy_i,
    output logic              pc_we_o,
    output logic              if_id_we_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_wb_we_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cnt_o,
    output logic [PERF_W-1:0] perf_flush_cnt_o,
    output logic [PERF_W-1:0] perf_wait_cnt_o,
`endif
    output logic              halted_o
);

    state_e            state_q, state_d, ret_q, ret_d, eff_state;
    logic              br_pend_q, br_pend_d, halt_seen_q, halt_seen_d;
    logic              ex_valid_q, ex_wr_q, ex_load_q, wb_valid_q;
    logic [REG_AW-1:0] ex_dest_q;
    logic              lu, br, stall_evt, wait_evt;
    logic              pc_we, if_id_we, flush, bubble, ex_wb_we;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid_i  (id_valid_i),
        .id_rs_i     (id_rs_i),
        .id_rt_i     (id_rt_i),
        .id_use_rs_i (id_use_rs_i),
        .id_use_rt_i (id_use_rt_i),
        .ex_valid_i  (ex_valid_q),
        .ex_load_i   (ex_load_q),
        .ex_wr_i     (ex_wr_q),
        .ex_dest_i   (ex_dest_q),
        .lu_o        (lu)
    );

    always_comb begin
        // On the MEM_WAIT release cycle the controller acts as the state it left.
        eff_state   = (state_q == StMemWait) ? ret_q : state_q;
        br          = ex_br_taken_i || br_pend_q;
        state_d     = state_q;
        ret_d       = ret_q;
        br_pend_d   = br_pend_q;
        halt_seen_d = halt_seen_q;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;
        ex_wb_we    = 1'b0;
        stall_evt   = 1'b0;
        wait_evt    = 1'b0;
        unique case (eff_state)
            StRun, StStallLu: begin
                if (dmem_busy_i) begin
                    wait_evt  = 1'b1;
                    state_d   = StMemWait;
                    ret_d     = eff_state;
                    br_pend_d = br;
                end else begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    ex_wb_we  = 1'b1;
                    state_d   = StRun;
                    br_pend_d = 1'b0;
                    if (br) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (lu) begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        bubble    = 1'b1;
                        stall_evt = 1'b1;
                        state_d   = StStallLu;
                    end else if (id_valid_i && id_is_halt_i) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        halt_seen_d = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end
            StDrain: begin
                if (dmem_busy_i) begin
                    wait_evt = 1'b1;
                    state_d  = StMemWait;
                    ret_d    = StDrain;
                end else begin
                    ex_wb_we = 1'b1;
                    bubble   = 1'b1;
                    state_d  = (halt_seen_q && !ex_valid_q && !wb_valid_q) ? StHalted : StDrain;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    // While reset is held the outputs show the NOP-injecting reset pattern.
    assign pc_we_o        = pc_we && !reset_i;
    assign if_id_we_o     = if_id_we && !reset_i;
    assign if_id_flush_o  = flush || reset_i;
    assign id_ex_bubble_o = bubble || reset_i;
    assign ex_wb_we_o     = ex_wb_we && !reset_i;
    assign halted_o       = (state_q == StHalted) && !reset_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StRun;
            ret_q       <= StRun;
            br_pend_q   <= 1'b0;
            halt_seen_q <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_dest_q   <= '0;
            wb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            br_pend_q   <= br_pend_d;
            halt_seen_q <= halt_seen_d;
            if (ex_wb_we) begin
                ex_valid_q <= id_valid_i && !bubble;
                ex_wr_q    <= id_wr_en_i && !bubble;
                ex_load_q  <= id_is_load_i && !bubble;
                ex_dest_q  <= id_dest_i;
                wb_valid_q <= ex_valid_q;
            end
        end
    end

    // The stall cycle moved the load to WB, so a second load-use here means broken tracking.
    assert property (@(posedge clk_i) disable iff (reset_i) (state_q == StStallLu) |-> !lu);

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (flush && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            if (wait_evt && (wait_cnt_q != '1))   wait_cnt_q  <= wait_cnt_q + PERF_W'(1);
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
    assign perf_wait_cnt_o  = wait_cnt_q;
`endif

endmodule
